// File: rtl/learn_clip_dst_serializer.sv
// learn_clip_dst_serializer: captures 8-lane FP32 result beats from learn_clip
// into a small beat FIFO and replays them as packed IEEE-754 words, lane 0
// first, on a valid/ready stream. Throttles the producer through clip_enable
// and records any beat that still arrives while the FIFO is full.
module learn_clip_dst_serializer #(
    parameter int DEPTH    = 4,
    parameter int HEADROOM = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dst_valid,
    input  logic [22:0] dst_man_0,
    input  logic [22:0] dst_man_1,
    input  logic [22:0] dst_man_2,
    input  logic [22:0] dst_man_3,
    input  logic [22:0] dst_man_4,
    input  logic [22:0] dst_man_5,
    input  logic [22:0] dst_man_6,
    input  logic [22:0] dst_man_7,
    input  logic [7:0]  dst_exp_0,
    input  logic [7:0]  dst_exp_1,
    input  logic [7:0]  dst_exp_2,
    input  logic [7:0]  dst_exp_3,
    input  logic [7:0]  dst_exp_4,
    input  logic [7:0]  dst_exp_5,
    input  logic [7:0]  dst_exp_6,
    input  logic [7:0]  dst_exp_7,
    input  logic        dst_sign_0,
    input  logic        dst_sign_1,
    input  logic        dst_sign_2,
    input  logic        dst_sign_3,
    input  logic        dst_sign_4,
    input  logic        dst_sign_5,
    input  logic        dst_sign_6,
    input  logic        dst_sign_7,
    output logic        clip_enable,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [2:0]  out_lane,
    output logic        out_last,
    output logic        overflow,
    output logic [7:0]  drop_count
);

    localparam int NUM_LANES = 8;
    localparam int VEC_W     = 32;
    localparam int AW        = $clog2(DEPTH);

    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_HI   = (AW+1)'(DEPTH - HEADROOM - 1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [NUM_LANES-1:0][22:0]      man;
    logic [NUM_LANES-1:0][7:0]       exp;
    logic [NUM_LANES-1:0]            sign;
    logic [NUM_LANES-1:0][VEC_W-1:0] beat_in;
    logic [NUM_LANES-1:0][VEC_W-1:0] mem [DEPTH];
    logic [NUM_LANES-1:0][VEC_W-1:0] head;

    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count, count_next;
    logic [2:0]    lane;
    logic          hs, pop, push, drop;

    assign man  = {dst_man_7, dst_man_6, dst_man_5, dst_man_4,
                   dst_man_3, dst_man_2, dst_man_1, dst_man_0};
    assign exp  = {dst_exp_7, dst_exp_6, dst_exp_5, dst_exp_4,
                   dst_exp_3, dst_exp_2, dst_exp_1, dst_exp_0};
    assign sign = {dst_sign_7, dst_sign_6, dst_sign_5, dst_sign_4,
                   dst_sign_3, dst_sign_2, dst_sign_1, dst_sign_0};

    // Each lane is packed into its IEEE-754 word before storage.
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_pack
        assign beat_in[g] = {sign[g], exp[g], man[g]};
    end

    assign out_valid = (count != '0);
    assign hs        = out_valid && out_ready;
    assign pop       = hs && (lane == 3'd7);
    // A full FIFO still accepts a beat when the head beat leaves this cycle.
    assign push      = dst_valid && ((count != CNT_FULL) || pop);
    assign drop      = dst_valid && (count == CNT_FULL) && !pop;

    assign head      = mem[rd_ptr];
    // Empty FIFO output is forced to zero rather than exposing stale storage.
    assign out_data  = out_valid ? head[lane] : '0;
    assign out_lane  = lane;
    assign out_last  = out_valid && (lane == 3'd7);

    // Occupancy after this cycle's push/pop; feeds count and the throttle.
    always_comb begin
        count_next = count;
        if (push && !pop)
            count_next = count + CNT_ONE;
        else if (pop && !push)
            count_next = count - CNT_ONE;
    end

    // Beat storage: no reset needed, contents are only read while count != 0.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= beat_in;
    end

    // Pointers, occupancy, lane counter, throttle and drop bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            lane        <= '0;
            clip_enable <= 1'b0;
            overflow    <= 1'b0;
            drop_count  <= '0;
        end else begin
            count       <= count_next;
            clip_enable <= (count_next <= CNT_HI);
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            if (hs)
                lane <= lane + 3'd1;
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != 8'hFF)
                    drop_count <= drop_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_learn_clip_dst_serializer.sv
// Self-checking bench for learn_clip_dst_serializer: a per-cycle queue model
// checks every output, plus table vectors and directed corner sequences.
module tb_learn_clip_dst_serializer;

    localparam int DEPTH    = 4;
    localparam int HEADROOM = 2;

    typedef logic [7:0][31:0] beat_t;

    typedef struct {
        logic        dv;
        logic        rdy;
        logic        exp_valid;
        logic [31:0] exp_data;
        logic [2:0]  exp_lane;
        logic        exp_last;
        logic        exp_en;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dst_valid = 1'b0;
    logic        out_ready = 1'b0;
    beat_t       cur_beat = '0;
    logic        clip_enable, out_valid, out_last, overflow;
    logic [31:0] out_data;
    logic [2:0]  out_lane;
    logic [7:0]  drop_count;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;

    // reference model state
    beat_t mq[$];
    int    m_lane  = 0;
    int    m_drops = 0;
    bit    m_ovf   = 1'b0;
    bit    m_en    = 1'b0;
    bit    m_full, m_hs, m_pop;

    always #5 clk = ~clk;

    learn_clip_dst_serializer #(.DEPTH(DEPTH), .HEADROOM(HEADROOM)) dut (
        .clk(clk), .rst(rst), .dst_valid(dst_valid),
        .dst_man_0(cur_beat[0][22:0]), .dst_man_1(cur_beat[1][22:0]),
        .dst_man_2(cur_beat[2][22:0]), .dst_man_3(cur_beat[3][22:0]),
        .dst_man_4(cur_beat[4][22:0]), .dst_man_5(cur_beat[5][22:0]),
        .dst_man_6(cur_beat[6][22:0]), .dst_man_7(cur_beat[7][22:0]),
        .dst_exp_0(cur_beat[0][30:23]), .dst_exp_1(cur_beat[1][30:23]),
        .dst_exp_2(cur_beat[2][30:23]), .dst_exp_3(cur_beat[3][30:23]),
        .dst_exp_4(cur_beat[4][30:23]), .dst_exp_5(cur_beat[5][30:23]),
        .dst_exp_6(cur_beat[6][30:23]), .dst_exp_7(cur_beat[7][30:23]),
        .dst_sign_0(cur_beat[0][31]), .dst_sign_1(cur_beat[1][31]),
        .dst_sign_2(cur_beat[2][31]), .dst_sign_3(cur_beat[3][31]),
        .dst_sign_4(cur_beat[4][31]), .dst_sign_5(cur_beat[5][31]),
        .dst_sign_6(cur_beat[6][31]), .dst_sign_7(cur_beat[7][31]),
        .clip_enable(clip_enable), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_lane(out_lane), .out_last(out_last),
        .overflow(overflow), .drop_count(drop_count)
    );

    // Behavioural model: a queue of whole beats plus a lane cursor.
    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_lane  = 0;
            m_drops = 0;
            m_ovf   = 1'b0;
            m_en    = 1'b0;
        end else begin
            m_full = (mq.size() == DEPTH);
            m_hs   = (mq.size() != 0) && out_ready;
            m_pop  = m_hs && (m_lane == 7);
            if (m_hs) m_lane = (m_lane + 1) % 8;
            if (m_pop) mq.delete(0);
            if (dst_valid) begin
                if (!m_full || m_pop) mq.push_back(cur_beat);
                else begin
                    m_ovf = 1'b1;
                    if (m_drops < 255) m_drops++;
                end
            end
            m_en = (mq.size() <= DEPTH - HEADROOM - 1);
        end
    end

    // Every cycle: full output tuple against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            logic [46:0] got, expv;
            logic        ev;
            logic [31:0] ed;
            ev   = (mq.size() != 0);
            ed   = ev ? mq[0][m_lane] : 32'h0;
            got  = {out_valid, out_data, out_lane, out_last, overflow, drop_count, clip_enable};
            expv = {ev, ed, 3'(m_lane), ev && (m_lane == 7), m_ovf, 8'(m_drops), m_en};
            n_tests++;
            if (got !== expv) begin
                n_fail++;
                $display("FAIL model_cycle t=%0t got=%h exp=%h (v,data,lane,last,ovf,drops,en)",
                         $time, got, expv);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", name, got, expv);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    function automatic logic [31:0] tword(input int k);
        return {1'(k & 1), 8'h80, 23'(32'h100 + k)};
    endfunction

    function automatic beat_t rand_beat();
        beat_t b;
        for (int k = 0; k < 8; k++) b[k] = $urandom;
        return b;
    endfunction

    task automatic do_reset();
        rst = 1'b1; dst_valid = 1'b0; out_ready = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic drain(input bit rnd);
        int n = 0;
        dst_valid = 1'b0;
        while (mq.size() != 0 && n < 2000) begin
            out_ready = rnd ? 1'($urandom % 2) : 1'b1;
            step();
            n++;
        end
        chk("drain_empty", 32'(out_valid), 32'h0);
    endtask

    initial begin : wdog
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin : main
        vec_t  tbl[10];
        beat_t tb_beat, nb;
        bit    h1, h2, en_c;

        for (int i = 0; i < 10; i++) begin
            tbl[i].dv        = (i == 0);
            tbl[i].rdy       = 1'b1;
            tbl[i].exp_valid = (i < 8);
            tbl[i].exp_data  = (i < 8) ? tword(i) : 32'h0;
            tbl[i].exp_lane  = (i < 8) ? 3'(i) : 3'd0;
            tbl[i].exp_last  = (i == 7);
            tbl[i].exp_en    = 1'b1;
        end
        for (int k = 0; k < 8; k++) tb_beat[k] = tword(k);

        // reset state
        rst = 1'b1;
        step();
        chk_on = 1'b1;
        step();
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_data", out_data, 32'h0);
        chk("rst_en", 32'(clip_enable), 32'h0);
        chk("rst_drops", 32'(drop_count), 32'h0);
        rst = 1'b0;
        step();
        chk("en_after_rst", 32'(clip_enable), 32'h1);

        // single beat, table driven
        cur_beat = tb_beat;
        for (int i = 0; i < 10; i++) begin
            dst_valid = tbl[i].dv;
            out_ready = tbl[i].rdy;
            step();
            chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].exp_valid));
            chk($sformatf("tbl%0d_data", i), out_data, tbl[i].exp_data);
            chk($sformatf("tbl%0d_lane", i), 32'(out_lane), 32'(tbl[i].exp_lane));
            chk($sformatf("tbl%0d_last", i), 32'(out_last), 32'(tbl[i].exp_last));
            chk($sformatf("tbl%0d_en", i), 32'(clip_enable), 32'(tbl[i].exp_en));
        end

        // overflow and saturation: push every cycle, nothing drains
        out_ready = 1'b0;
        for (int p = 1; p <= 262; p++) begin
            dst_valid = 1'b1;
            cur_beat  = rand_beat();
            step();
            if (p == 4) chk("ovf_p4_drops", 32'(drop_count), 32'h0);
            if (p == 5) chk("ovf_p5_drops", 32'(drop_count), 32'h1);
            if (p == 6) chk("ovf_p6_drops", 32'(drop_count), 32'h2);
            if (p == 258) chk("ovf_p258_drops", 32'(drop_count), 32'd254);
            if (p == 259) chk("ovf_p259_drops", 32'(drop_count), 32'd255);
            if (p == 262) chk("ovf_sat_drops", 32'(drop_count), 32'd255);
        end
        chk("ovf_sticky", 32'(overflow), 32'h1);
        drain(1'b0);

        // full FIFO: push coincident with lane-7 handshake
        do_reset();
        for (int p = 0; p < 4; p++) begin
            dst_valid = 1'b1; cur_beat = rand_beat(); step();
        end
        dst_valid = 1'b0; out_ready = 1'b1;
        repeat (7) step();
        chk("fp_lane7", 32'(out_lane), 32'd7);
        dst_valid = 1'b1; cur_beat = rand_beat();
        step();
        chk("fp_no_drop", 32'(drop_count), 32'h0);
        chk("fp_no_ovf", 32'(overflow), 32'h0);
        chk("fp_lane_wrap", 32'(out_lane), 32'h0);
        out_ready = 1'b0; cur_beat = rand_beat();
        step();
        chk("fp_still_full", 32'(drop_count), 32'h1);
        drain(1'b0);

        // reset mid-beat with three beats queued
        do_reset();
        for (int p = 0; p < 5; p++) begin
            dst_valid = 1'b1; cur_beat = rand_beat(); step();
        end
        dst_valid = 1'b0; out_ready = 1'b1;
        repeat (13) step();
        chk("mid_lane5", 32'(out_lane), 32'd5);
        chk("mid_ovf_set", 32'(overflow), 32'h1);
        rst = 1'b1; dst_valid = 1'b1; cur_beat = rand_beat();
        step();
        chk("mid_rst_valid", 32'(out_valid), 32'h0);
        chk("mid_rst_ovf", 32'(overflow), 32'h0);
        chk("mid_rst_drops", 32'(drop_count), 32'h0);
        rst = 1'b0; out_ready = 1'b0;
        nb = rand_beat(); cur_beat = nb;
        step();
        dst_valid = 1'b0;
        chk("mid_new_lane", 32'(out_lane), 32'h0);
        chk("mid_new_data", out_data, nb[0]);
        drain(1'b0);

        // back-to-back producer with 2-cycle enable latency
        h1 = 1'b0; h2 = 1'b0;
        for (int c = 0; c < 200; c++) begin
            out_ready = 1'b1;
            en_c      = clip_enable;
            dst_valid = h2;
            cur_beat  = rand_beat();
            h2 = h1; h1 = en_c;
            step();
        end
        chk("b2b_no_drop", 32'(drop_count), 32'h0);
        drain(1'b0);

        // random ready, 16 beats, scoreboard via model
        for (int b = 0; b < 16; b++) begin
            dst_valid = 1'b1; cur_beat = rand_beat();
            out_ready = 1'($urandom % 2);
            step();
            dst_valid = 1'b0;
            repeat ($urandom_range(0, 5)) begin
                out_ready = 1'($urandom % 2);
                step();
            end
        end
        drain(1'b1);

        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
